// File: rtl/dmem_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder_if
// Bus bundle between the core's data port (master) and the data-memory /
// MMIO responder (slave). Also carries the console byte stream and the
// TOHOST completion outputs so a single handle reaches the responder.
//
// Signals:
//   MemWrite      master->slave  store strobe
//   DataAdr[31:0] master->slave  byte address
//   WriteData     master->slave  store data
//   ReadData      slave->master  load data (combinational from DataAdr)
//   ConsoleValid  slave->master  console FIFO head byte available
//   ConsoleData   slave->master  console FIFO head byte
//   ConsoleReady  master->slave  sink accepts the head byte
//   Done/Pass     slave->master  TOHOST completion flags
//   ExitCode      slave->master  data of the first TOHOST write
// ---------------------------------------------------------------------------
interface dmem_mmio_responder_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        ConsoleValid;
   logic [7:0]  ConsoleData;
   logic        ConsoleReady;
   logic        Done;
   logic        Pass;
   logic [31:0] ExitCode;

   modport master (
      output MemWrite, DataAdr, WriteData, ConsoleReady,
      input  ReadData, ConsoleValid, ConsoleData, Done, Pass, ExitCode
   );

   modport slave (
      input  MemWrite, DataAdr, WriteData, ConsoleReady,
      output ReadData, ConsoleValid, ConsoleData, Done, Pass, ExitCode
   );
endinterface

// File: rtl/dmem_mmio_responder.sv
// ---------------------------------------------------------------------------
// dmem_mmio_responder
// Data-side memory responder: word-addressed data RAM plus an MMIO window
// holding a byte console FIFO (drained over valid/ready) and a TOHOST
// register that latches end-of-test and pass/fail.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high
//   bus    dmem_mmio_responder_if.slave (store/load port, console stream,
//          Done/Pass/ExitCode)
//
// Memory map (bits [1:0] ignored everywhere):
//   0 .. RAM_WORDS*4-1   data RAM (not cleared by reset)
//   MMIO_BASE+0          CONSOLE  write pushes WriteData[7:0], reads 0
//   MMIO_BASE+4          STATUS   {Done, overflow, empty, full, count[7:0]}
//   MMIO_BASE+8          TOHOST   first write latches, reads ExitCode
//   anything else        reads 0, writes ignored
//
// Build option: define DMEM_MMIO_CONSOLE_EN to include the console FIFO.
// Without it, CONSOLE writes are ignored, the stream is idle and STATUS
// reports a permanently empty FIFO.
// ---------------------------------------------------------------------------
module dmem_mmio_responder #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input logic                  clk,
   input logic                  reset,
   dmem_mmio_responder_if.slave bus
);

   localparam int unsigned RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
   localparam logic [31:0] CONS_ADR  = MMIO_BASE;
   localparam logic [31:0] STAT_ADR  = MMIO_BASE + 32'd4;
   localparam logic [31:0] HOST_ADR  = MMIO_BASE + 32'd8;

   // ---------------- address decode ----------------
   logic sel_ram, sel_cons, sel_stat, sel_host;
   logic [RAM_AW-1:0] ram_idx;

   // RAM_BYTES is a multiple of 4, so the byte-level compare already
   // ignores bits [1:0].
   assign sel_ram  = {1'b0, bus.DataAdr} < RAM_BYTES;
   assign sel_cons = bus.DataAdr[31:2] == CONS_ADR[31:2];
   assign sel_stat = bus.DataAdr[31:2] == STAT_ADR[31:2];
   assign sel_host = bus.DataAdr[31:2] == HOST_ADR[31:2];
   assign ram_idx  = bus.DataAdr[RAM_AW+1:2];

   // ---------------- data RAM ----------------
   logic [31:0] ram_q [RAM_WORDS];

   // Reset blocks the write so a store in the reset cycle is lost, but the
   // contents themselves survive reset.
   always_ff @(posedge clk) begin
      if (!reset && bus.MemWrite && sel_ram) begin
         ram_q[ram_idx] <= bus.WriteData;
      end
   end

   // ---------------- TOHOST ----------------
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic [31:0] exit_q, exit_d;

   always_comb begin
      done_d = done_q;
      pass_d = pass_q;
      exit_d = exit_q;
      // Only the first write after reset is captured.
      if (bus.MemWrite && sel_host && !done_q) begin
         done_d = 1'b1;
         pass_d = (bus.WriteData == 32'd0);
         exit_d = bus.WriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
         pass_q <= 1'b0;
         exit_q <= 32'd0;
      end else begin
         done_q <= done_d;
         pass_q <= pass_d;
         exit_q <= exit_d;
      end
   end

   assign bus.Done     = done_q;
   assign bus.Pass     = pass_q;
   assign bus.ExitCode = exit_q;

   // ---------------- console FIFO ----------------
   logic [31:0] status;

`ifdef DMEM_MMIO_CONSOLE_EN
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push_req, do_push, do_pop;

   always_comb begin
      push_req = bus.MemWrite && sel_cons;
      do_pop   = (count_q != '0) && bus.ConsoleReady;
      // A same-cycle pop frees the slot, so a push into a full FIFO is
      // still accepted then.
      do_push  = push_req && ((count_q != CW'(FIFO_DEPTH)) || do_pop);
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (do_push) begin
         wptr_d = (wptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (do_pop) begin
         rptr_d = (rptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
      if (push_req && !do_push) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage is cleared on reset so ConsoleData reads 0 afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_q[i] <= 8'd0;
         end
      end else if (do_push) begin
         fifo_q[wptr_q] <= bus.WriteData[7:0];
      end
   end

   assign bus.ConsoleValid = (count_q != '0);
   assign bus.ConsoleData  = fifo_q[rptr_q];
   assign status = {20'd0, done_q, ovf_q, (count_q == '0),
                    (count_q == CW'(FIFO_DEPTH)), 8'(count_q)};
`else
   logic unused_cons;
   assign unused_cons      = &{1'b0, bus.ConsoleReady, 8'(FIFO_DEPTH)};
   assign bus.ConsoleValid = 1'b0;
   assign bus.ConsoleData  = 8'd0;
   assign status = {20'd0, done_q, 1'b0, 1'b1, 1'b0, 8'd0};
`endif

   // ---------------- load mux ----------------
   logic [31:0] rdata;

   always_comb begin
      rdata = 32'd0;
      if (sel_ram) begin
         rdata = ram_q[ram_idx];
      end else if (sel_stat) begin
         rdata = status;
      end else if (sel_host) begin
         rdata = exit_q;
      end
   end

   assign bus.ReadData = rdata;

endmodule
